// File: rtl/asip_trace_pkg.sv
// asip_trace_pkg: shared types and constants for the memory-write tracer.
//   REC_W          width of one trace record in bits
//   BYTES_PER_REC  number of stream bytes per record
//   trace_rec_t    one captured write; addr sits in the top 16 bits so the
//                  packed struct is already in MSB-first stream order
//   trace_state_t  serializer FSM states
package asip_trace_pkg;

    localparam int unsigned REC_W         = 64;
    localparam int unsigned BYTES_PER_REC = 8;

    typedef struct packed {
        logic [15:0] addr;
        logic [47:0] data;
    } trace_rec_t;

    typedef enum logic {
        IDLE,
        SEND
    } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of trace_rec_t records.
//   clk    system clock
//   rst    synchronous active-low reset (empties the FIFO)
//   push   write din at the tail (caller guarantees room, or a same-cycle pop)
//   pop    advance the head (caller guarantees not empty)
//   din    record to store
//   dout   record at the head (combinational read of the head slot)
//   count  number of records held
//   full   count == DEPTH
//   empty  count == 0
module trace_fifo
    import asip_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  trace_rec_t                 din,
    output trace_rec_t                 dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    trace_rec_t       mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A push into a full FIFO with a same-cycle pop writes the slot being
    // read; dout still shows the old head because the write lands at the edge.
    assign dout  = mem[rptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: rtl/mem_write_tracer.sv
// mem_write_tracer: captures memory-stage writes and streams them out as
// 8-byte records (addr hi, addr lo, data[47:40] .. data[7:0]).
//   clk         system clock
//   rst         synchronous active-low reset
//   wr_en       write strobe; one record captured per high cycle
//   wr_addr     write address
//   wr_data     write data
//   byte_out    current stream byte
//   byte_valid  byte_out is valid
//   byte_ready  sink accepts byte_out when byte_valid is high
//   clr_ovf     clears overflow and drop_cnt
//   fifo_count  records queued (not counting the one being sent)
//   full        fifo_count == DEPTH
//   overflow    sticky: a write has been dropped
//   drop_cnt    number of dropped writes, saturating at 255
module mem_write_tracer
    import asip_trace_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 48,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [7:0]                 byte_out,
    output logic                       byte_valid,
    input  logic                       byte_ready,
    input  logic                       clr_ovf,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       full,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_REC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_REC - 1);

    trace_state_t     state;
    logic [REC_W-1:0] shreg;
    logic [IDX_W-1:0] byte_idx;

    trace_rec_t rec_in;
    trace_rec_t head;
    logic       push;
    logic       pop;
    logic       drop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       last_hs;

    always_comb begin
        rec_in      = '0;
        rec_in.addr = wr_addr;
        rec_in.data = wr_data;
    end

    // Pop only when idle, or on the final handshake of the current record so
    // consecutive records stream without a bubble.
    always_comb begin
        last_hs = (state == SEND) && byte_ready && (byte_idx == LAST_IDX);
        pop     = !fifo_empty && ((state == IDLE) || last_hs);
        push    = wr_en && (!fifo_full || pop);
        drop    = wr_en && !push;
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rec_in),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign full     = fifo_full;
    assign byte_out = shreg[REC_W-1 -: 8];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            byte_idx   <= '0;
            byte_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg      <= head;
                        byte_idx   <= '0;
                        byte_valid <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (byte_ready) begin
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= '0;
                            if (pop) begin
                                shreg <= head;
                            end else begin
                                shreg      <= '0;
                                byte_valid <= 1'b0;
                                state      <= IDLE;
                            end
                        end else begin
                            shreg    <= {shreg[REC_W-9:0], 8'h00};
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    byte_valid <= 1'b0;
                end
            endcase
        end
    end

    // Clear shares reset priority, so a drop in the clearing cycle is lost.
    always_ff @(posedge clk) begin
        if (!rst || clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_write_tracer.md
Name: mem_write_tracer

Overview:
- Sits downstream of the processor's memory stage.
- Captures every data-memory write (the 16-bit address and the 48-bit write data, qualified by the memory-stage write strobe) into a small FIFO.
- Drains the FIFO as an 8-byte-per-record byte stream over a valid/ready handshake, so memory writes can be dumped to a UART or a text logger without stalling the pipeline.
- Drops writes when full and flags the loss.

Parameters:
- ADDR_W, 16, width of the captured write address.
- DATA_W, 48, width of the captured write data.
- DEPTH, 8, FIFO depth in records (power of two, at least 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- wr_en  in  1  memory-stage write strobe; a record is captured in every cycle it is high.
- wr_addr  in  ADDR_W  memory-stage write address.
- wr_data  in  DATA_W  memory-stage write data.
- byte_out  out  8  current stream byte.
- byte_valid  out  1  byte_out holds a valid byte.
- byte_ready  in  1  sink accepts byte_out when byte_valid and byte_ready are both high.
- clr_ovf  in  1  clears overflow and drop_cnt; same priority as reset for those two outputs.
- fifo_count  out  $clog2(DEPTH+1)  number of records held in the FIFO (excludes the record being sent).
- full  out  1  fifo_count == DEPTH.
- overflow  out  1  sticky flag: at least one write has been dropped.
- drop_cnt  out  8  count of dropped writes; saturates at 255.

Behaviour:
- Reset (rst low at an edge): FIFO emptied; state IDLE; byte_valid=0; byte_out=0; fifo_count=0; full=0; overflow=0; drop_cnt=0.
- Reset mid-record abandons the record in flight; no partial record resumes after reset.
- Record format, 64 bits, sent MSB byte first:
  - bytes 0-1: address, high byte then low byte.
  - bytes 2-7: data, bits 47:40 first down to bits 7:0.
- Push rule: when wr_en=1, the record is accepted if fifo_count<DEPTH, or if a pop occurs in the same cycle.
- Full with no pop: the record is dropped, overflow is set, and drop_cnt increments (saturating at 255).
- clr_ovf=1 clears overflow and drop_cnt at the edge. If a drop happens in the same cycle, the clear wins, then the flags re-arm on the next drop.
- FIFO: circular read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; fifo_count is tracked separately.
- A simultaneous push and pop leaves fifo_count unchanged.
- FSM states:
  - IDLE: byte_valid=0. If fifo_count>0, pop the head into a 64-bit shift register, set byte_idx=0, go to SEND.
  - SEND: byte_valid=1 and byte_out=shreg[63:56]. On a handshake, shift shreg left by 8 and increment byte_idx.
  - On the handshake at byte_idx==7: if fifo_count>0, pop the next record directly with no idle bubble and stay in SEND; else go to IDLE.
  - While byte_valid=1 and byte_ready=0, byte_out and byte_valid hold stable.
- Latency: wr_en high in cycle t with the tracer idle and the FIFO empty gives byte_valid=1 in cycle t+2 with byte_out = address high byte.
- Throughput with byte_ready tied high is 1 byte per cycle and 1 record per 8 cycles, back to back.
- Pop happens only in IDLE, or on the last-byte handshake in SEND.
- All outputs are registered except full, which is decoded from the registered fifo_count.

Decomposition:
- Package asip_trace_pkg holds:
  - localparams REC_W=64 and BYTES_PER_REC=8.
  - trace_rec_t, a packed struct with fields addr[15:0] and data[47:0].
  - trace_state_t, an enum with values IDLE and SEND.
- One sub-module, trace_fifo: a synchronous FIFO of trace_rec_t, parameterised by DEPTH, exposing push/pop/count/full/empty.
- The top level holds the FSM, the shift register, the drop logic and the flags.

Test Plan:
- Reset then a single write of addr=0x1234, data=0xA1B2C3D4E5F6, byte_ready=1 -> byte_valid rises 2 cycles later; the stream is 12 34 A1 B2 C3 D4 E5 F6 on consecutive cycles; then byte_valid=0 and fifo_count=0.
- Three back-to-back writes (addr 0x0001/0x0002/0x0003, data = addr replicated) with byte_ready=1 -> 24 contiguous valid bytes with no bubble between records; fifo_count peaks at 2.
- byte_ready=0 held for 10 cycles mid-record (after byte 3) -> byte_out stays at byte 3 value and byte_valid stays 1; the stream resumes correctly when ready returns.
- byte_ready=0 with DEPTH+3=11 writes -> full=1 after 9 writes (1 in shreg plus 8 in FIFO); overflow=1; drop_cnt=2; the drained records match the first 9 writes in order.
- Full FIFO with a push coinciding with a last-byte pop -> push accepted, fifo_count stays at 8, overflow stays 0; then clr_ovf after a prior drop -> overflow=0, drop_cnt=0.
- rst low asserted during byte 5 of a record with 3 records queued -> next cycle byte_valid=0, fifo_count=0, flags 0; a subsequent write streams a clean full record.
